// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: op codes, flag layout, FSM states.
package alu_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        ORR = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-input round-robin grant; the pointer flips away from each granted requester.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = 1'b0;
        if (req_i == 2'b11) begin
            gnt_id_o = ptr_q;
        end else begin
            gnt_id_o = req_i[1];
        end
        ptr_d = ptr_q;
        if (en_i && gnt_valid_o) begin
            ptr_d = ~gnt_id_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional ALU_ARBITER_STICKY_FLAGS_EN adds the nzcv_q condition-code register.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][N-1:0]     req_a,
    input  logic [1:0][N-1:0]     req_b,
    input  logic [1:0][1:0]       req_sel,
    output logic [N-1:0]          alu_a,
    output logic [N-1:0]          alu_b,
    output logic [1:0]            alu_sel,
    input  logic [N-1:0]          alu_result,
    input  logic [3:0]            alu_flags,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [N-1:0]          rsp_result,
    output logic [3:0]            rsp_flags,
    output logic                  busy,
`ifdef ALU_ARBITER_STICKY_FLAGS_EN
    output logic [3:0]            nzcv_q,
`endif
    output arb_state_t            dbg_state
);

    // Request channel: a transfer happens on a cycle where req_valid[i] and
    // req_ready[i] are both high; response channel likewise with rsp_valid/rsp_ready.

    arb_state_t state_q, state_d;
    logic       gnt_q;
    logic [N-1:0] a_q, b_q, result_q;
    alu_op_t    sel_q;
    alu_flags_t flags_q;
    logic       gnt_valid;
    logic       gnt_id;
    logic       arb_en;

    assign arb_en = (state_q == IDLE);

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_valid),
        .en_i        (arb_en),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    req_ready = id_to_onehot(gnt_id);
                    state_d   = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                rsp_valid = id_to_onehot(gnt_q);
                if (rsp_ready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= ADD;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && gnt_valid) begin
                gnt_q <= gnt_id;
                a_q   <= req_a[gnt_id];
                b_q   <= req_b[gnt_id];
                sel_q <= alu_op_t'(req_sel[gnt_id]);
            end
            if (state_q == EXEC) begin
                result_q <= alu_result;
                flags_q  <= alu_flags_t'(alu_flags);
            end
        end
    end

`ifdef ALU_ARBITER_STICKY_FLAGS_EN
    // Only arithmetic ops update the condition codes; logic ops preserve them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_q <= 4'b0000;
        end else if (state_q == EXEC && !sel_q[1]) begin
            nzcv_q <= alu_flags;
        end
    end
`endif

    // Operand registers only change on a grant, so the ALU inputs hold between ops.
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = sel_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule
